mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage data-memory access controller for the pipelined MIPS core.
- Store path (narrowing direction): packs byte/half/word store data into 32-bit word lanes with byte enables.
- Load path: extracts the addressed lane from the returned word and sign- or zero-extends it to 32 bits.
- Sits between the EX/MEM pipeline register and a variable-latency data RAM. Drives a stall to the pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles spent in ACCESS waiting for mem_ack before the access is aborted with a timeout error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  block can accept a request; equals (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for stores and words
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- mem_en  out  1  RAM access strobe
- mem_we  out  4  byte-lane write enables; bit i = bits [8i+7:8i]
- mem_addr  out  30  word address (req_addr[31:2])
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  RAM read data, valid when mem_ack=1
- mem_ack  in  1  RAM completion; sampled only in ACCESS
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and on error
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size
- stall  out  1  hold the pipeline

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, wait counter=0. All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err. req_ready=1. Reset during ACCESS abandons the access with no response and deasserts mem_en immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on req_valid:
  - Fault check:
    - req_size==11 -> error 11.
    - half with addr[0]=1 -> error 01.
    - word with addr[1:0]!=0 -> error 01.
  - On a fault: go to RESP with that error. No RAM access is issued; mem_en stays 0.
  - Otherwise: register mem_addr, mem_we and mem_wdata, and the load attributes (size, unsigned, addr[1:0]). Set mem_en=1 and go to ACCESS.
- Store packing:
  - byte: mem_wdata={4{wdata[7:0]}}, mem_we=0001<<addr[1:0].
  - half: mem_wdata={2{wdata[15:0]}}, mem_we=0011 (addr[1]=0) or 1100.
  - word: mem_wdata=wdata, mem_we=1111.
- Loads: mem_we=0000.
- ACCESS:
  - mem_en held at 1 and all mem_* outputs held stable until mem_ack.
  - On mem_ack: mem_en<=0. For loads, rsp_rdata<=extend(lane). Then go to RESP with err 00.
  - Counter increments each ACCESS cycle without ack. When it reaches TIMEOUT: mem_en<=0, err 10, rsp_rdata 0, go to RESP.
  - Counter clears on leaving ACCESS.
- Load extraction, little-endian, lane=addr[1:0]:
  - byte: rdata[8*lane+7:8*lane].
  - half: rdata[15:0] (addr[1]=0) or rdata[31:16].
  - Sign bit is replicated to 32 bits unless req_unsigned=1, in which case the value is zero-filled.
- RESP:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - rsp_rdata and rsp_err hold until the next response.
- Latency:
  - Request accepted at edge 0 -> ACCESS from cycle 1.
  - mem_ack in cycle k -> rsp_valid in cycle k+1.
  - Minimum 2 cycles; a faulted request responds in cycle 1.
- stall = (IDLE & req_valid) | ACCESS. It is 0 in RESP so the pipeline advances in the cycle rsp_valid is high.
- mem_ack outside ACCESS is ignored.
- A new request in the RESP cycle is not accepted (req_ready=0). It is taken in the following IDLE cycle.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - error codes ERR_OK/ERR_ALIGN/ERR_TIMEOUT/ERR_SIZE
  - the state enum
- One sub-module, load_ext (combinational): inputs rdata[31:0], size, unsigned, lane[1:0]; output 32-bit extended value. It is verified standalone.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5, ack after 1 cycle -> mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x400; rsp_valid in cycle 2 with err 00.
- Signed/unsigned byte load: mem_rdata=0x80FF7F01, addr lane 2 -> signed rsp_rdata=0xFFFFFFFF, unsigned 0x000000FF; lane 3 signed -> 0xFFFFFF80.
- Half load: addr=0x2002, rdata=0x8001_1234, signed -> 0xFFFF8001; unsigned -> 0x00008001; word load 0xDEADBEEF passes unchanged.
- Faults: half at addr=0x0001 -> err 01; word at 0x0006 -> err 01; size=11 -> err 11. In all three, mem_en never asserts and rsp_valid is in cycle 1.
- Timeout: TIMEOUT=4, no ack -> mem_en high for 4 cycles then drops; rsp err 10, rsp_rdata 0; stall drops in the RESP cycle.
- Reset mid-access: rst_n low during ACCESS -> mem_en=0 immediately, no rsp_valid. After release, a fresh word load at 0x0 completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access controller: access sizes, response
// error codes, FSM states and the request fault classifier.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SIZE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Illegal size wins over misalignment so the pipeline sees the root cause.
  function automatic logic [1:0] faultCode(input logic [1:0] size, input logic [1:0] lane);
    logic [1:0] code;
    code = ERR_OK;
    if (size == SZ_ILL)
      code = ERR_SIZE;
    else if ((size == SZ_HALF) && lane[0])
      code = ERR_ALIGN;
    else if ((size == SZ_WORD) && (lane != 2'b00))
      code = ERR_ALIGN;
    return code;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-path lane extraction: selects the addressed byte/half of a little-endian
// word and sign- or zero-extends it to 32 bits. Words pass through untouched.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access controller: packs stores into byte lanes, issues
// one access to a variable-latency RAM, and returns an extended load or an error.
module mem_stage_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        stall
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [CW-1:0] r_cnt;

  logic        r_memEn;
  logic [3:0]  r_memWe;
  logic [29:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_rspValid;
  logic [31:0] r_rspRdata;
  logic [1:0]  r_rspErr;

  logic        r_isStore;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;

  logic [1:0]  w_fault;
  logic        w_timeout;
  logic [3:0]  w_packWe;
  logic [31:0] w_packData;
  logic [31:0] w_extData;

  assign w_fault   = faultCode(req_size, req_addr[1:0]);
  assign w_timeout = (r_state == ST_ACCESS) && !mem_ack && (r_cnt == CNT_LAST);

  // Store lane packing; data is replicated so the RAM only needs byte enables.
  always_comb begin
    w_packWe   = 4'b0000;
    w_packData = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        w_packData = {4{req_wdata[7:0]}};
        w_packWe   = 4'b0001 << req_addr[1:0];
      end
      SZ_HALF: begin
        w_packData = {2{req_wdata[15:0]}};
        w_packWe   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: w_packWe = 4'b1111;
      default: w_packWe = 4'b0000;
    endcase
    if (!req_we)
      w_packWe = 4'b0000;
  end

  load_ext u_loadExt (
    .i_rdata    (mem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_lane     (r_lane),
    .o_data     (w_extData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid)
          w_nextState = (w_fault != ERR_OK) ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (mem_ack || w_timeout)
          w_nextState = ST_RESP;
      end
      ST_RESP: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath registers; reset during ACCESS drops mem_en with no response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_memEn    <= 1'b0;
      r_memWe    <= 4'b0000;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= ERR_OK;
      r_isStore  <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
    end else begin
      r_rspValid <= 1'b0;
      if ((r_state == ST_ACCESS) && (w_nextState == ST_ACCESS))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_fault != ERR_OK) begin
              r_rspValid <= 1'b1;
              r_rspErr   <= w_fault;
              r_rspRdata <= '0;
            end else begin
              r_memEn    <= 1'b1;
              r_memAddr  <= req_addr[31:2];
              r_memWe    <= w_packWe;
              r_memWdata <= w_packData;
              r_isStore  <= req_we;
              r_size     <= req_size;
              r_unsigned <= req_unsigned;
              r_lane     <= req_addr[1:0];
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_memEn    <= 1'b0;
            r_rspValid <= 1'b1;
            r_rspErr   <= ERR_OK;
            r_rspRdata <= r_isStore ? 32'h0 : w_extData;
          end else if (w_timeout) begin
            r_memEn    <= 1'b0;
            r_rspValid <= 1'b1;
            r_rspErr   <= ERR_TIMEOUT;
            r_rspRdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = r_memEn;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: a vector table drives single accesses while a
// response queue checks data, error code and response cycle.
module tb_mem_stage_access;
  import mem_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    logic [1:0]  expErr;
    logic [31:0] expRdata;
    logic [3:0]  expWe;
    logic [31:0] expWdata;
  } vec_t;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          cycle;
  } resp_t;

  localparam logic [31:0] GARBAGE = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        stall;

  int    checks = 0;
  int    errors = 0;
  int    cycleCnt = 0;
  resp_t expQ[$];
  vec_t  vecs[19];

  mem_stage_access #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .stall        (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Response side of the scoreboard: every rsp_valid pulse must match the head.
  always @(negedge clk) begin : rspMonitor
    resp_t e;
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_cycle", cycleCnt, e.cycle);
        checkOutput("rsp_stall", {31'd0, stall}, 32'd0);
        checkOutput("rsp_mem_en", {31'd0, mem_en}, 32'd0);
      end
    end
  end

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("rsp_seen", expQ.size(), 0);
    expQ.delete();
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    bit isFault;
    int start;
    isFault = (v.expErr != ERR_OK);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    start = cycleCnt;
    expQ.push_back('{v.expErr, v.expRdata, start + (isFault ? 1 : v.ackDelay + 2)});
    #1;
    checkOutput("req_stall", {31'd0, stall}, 32'd1);
    checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (isFault) begin
      checkOutput("fault_mem_en", {31'd0, mem_en}, 32'd0);
    end else begin
      checkOutput("mem_we", {28'd0, mem_we}, {28'd0, v.expWe});
      checkOutput("mem_addr", {2'b00, mem_addr}, {2'b00, v.addr[31:2]});
      if (v.we) checkOutput("mem_wdata", mem_wdata, v.expWdata);
      for (int d = 0; d <= v.ackDelay; d++) begin
        checkOutput("access_mem_en", {31'd0, mem_en}, 32'd1);
        checkOutput("access_stall", {31'd0, stall}, 32'd1);
        if (d == v.ackDelay) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = GARBAGE;
      end
    end
    waitDrain();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    vecs[0]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, ERR_OK, 32'h0, 4'b1000, 32'hA5A5_A5A5};
    vecs[1]  = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0042, 32'h1234_BEEF, 32'h0, 2, ERR_OK, 32'h0, 4'b1100, 32'hBEEF_BEEF};
    vecs[2]  = '{1'b1, SZ_WORD, 1'b1, 32'h0000_0108, 32'hCAFE_F00D, 32'h0, 0, ERR_OK, 32'h0, 4'b1111, 32'hCAFE_F00D};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 0, ERR_OK, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0006, 32'h0, 32'h80FF_7F01, 1, ERR_OK, 32'h0000_00FF, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0007, 32'h0, 32'h80FF_7F01, 0, ERR_OK, 32'hFFFF_FF80, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h0, 32'h80FF_7F01, 0, ERR_OK, 32'h0000_007F, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 0, ERR_OK, 32'h0000_0080, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, ERR_OK, 32'hFFFF_8001, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, ERR_OK, 32'h0000_8001, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_F00F, 0, ERR_OK, 32'hFFFF_F00F, 4'b0000, 32'h0};
    vecs[11] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_2000, 32'h0, 32'h1234_F00F, 0, ERR_OK, 32'h0000_F00F, 4'b0000, 32'h0};
    vecs[12] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_1001, 32'h1234_5677, 32'h0, 1, ERR_OK, 32'h0, 4'b0010, 32'h7777_7777};
    vecs[13] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 0, ERR_OK, 32'h1357_9BDF, 4'b0000, 32'h0};
    vecs[14] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, ERR_ALIGN, 32'h0, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, ERR_ALIGN, 32'h0, 4'b0000, 32'h0};
    vecs[16] = '{1'b1, SZ_ILL,  1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, ERR_SIZE, 32'h0, 4'b0000, 32'h0};
    vecs[17] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0, ERR_ALIGN, 32'h0, 4'b0000, 32'h0};
    vecs[18] = '{1'b0, SZ_WORD, 1'b1, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3, ERR_OK, 32'hDEAD_BEEF, 4'b0000, 32'h0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = GARBAGE; mem_ack = 1'b0;
    #1;
    checkOutput("reset_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("reset_mem_we", {28'd0, mem_we}, 32'd0);
    checkOutput("reset_mem_addr", {2'b00, mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++)
      applyStimulus(vecs[i]);

    // Timeout with no ack, then a request raised during RESP and a stray ack.
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020;
    c = cycleCnt;
    expQ.push_back('{ERR_TIMEOUT, 32'h0, c + 5});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("timeout_mem_en_high", {31'd0, mem_en}, 32'd1);
      @(posedge clk); #1;
    end
    checkOutput("timeout_mem_en_low", {31'd0, mem_en}, 32'd0);
    checkOutput("resp_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1; req_addr = 32'h0000_0044; mem_ack = 1'b1;
    expQ.push_back('{ERR_OK, 32'h1122_3344, c + 8});
    @(posedge clk); #1;
    checkOutput("resp_req_not_taken", {31'd0, mem_en}, 32'd0);
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("idle_stall", {31'd0, stall}, 32'd1);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("late_req_mem_en", {31'd0, mem_en}, 32'd1);
    checkOutput("late_req_mem_addr", {2'b00, mem_addr}, 32'h11);
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = GARBAGE;
    waitDrain();

    // Reset in the middle of an access abandons it silently.
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("pre_reset_mem_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    applyStimulus('{1'b0, SZ_WORD, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1, ERR_OK, 32'h0BAD_F00D, 4'b0000, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
